// File: rtl/fp_unpack_stage.sv
// ============================================================================
//  Module   : fp_unpack_stage
//  Purpose  : Two-stage valid/ready IEEE754 operand unpacker. It classifies the
//             word, restores the hidden bit and normalises subnormals.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_unpack_stage #(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic [NX+NM:0]   IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_SIGN,
  output logic [NX+1:0]    OUT_EXP,
  output logic [NM:0]      OUT_MANT,
  output logic [2:0]       OUT_CLASS,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int EW   = NX + 2;
  localparam int LZW  = $clog2(NM + 1);
  localparam int BIAS = 2 ** (NX - 1) - 1;

  localparam logic [EW-1:0] BIAS_W  = EW'(BIAS);
  localparam logic [NX-1:0] EXP_MAX = '1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUBN = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_SNAN = 3'd4;
  localparam logic [2:0] CLS_QNAN = 3'd5;

  logic [NX-1:0]  in_exp;
  logic [NM-1:0]  in_frac;
  logic [LZW-1:0] lz_d;
  logic [2:0]     class_d;

  logic           s1_valid_q;
  logic           s1_sign_q;
  logic [NX-1:0]  s1_exp_q;
  logic [NM-1:0]  s1_frac_q;
  logic [2:0]     s1_class_q;
  logic [LZW-1:0] s1_lz_q;

  logic           out_valid_q;
  logic           out_sign_q;
  logic [EW-1:0]  out_exp_q;
  logic [NM:0]    out_mant_q;
  logic [2:0]     out_class_q;

  logic [EW-1:0]  shamt;
  logic [EW-1:0]  exp_d;
  logic [NM:0]    mant_d;

  logic           s2_adv;
  logic           s1_adv;

  assign in_exp  = IN_DATA[NM +: NX];
  assign in_frac = IN_DATA[NM-1:0];

  assign s2_adv   = !out_valid_q || OUT_READY;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign IN_READY = s1_adv;

  // Highest set bit wins because the scan runs from LSB upward.
  always_comb begin
    lz_d = LZW'(NM);
    for (int i = 0; i < NM; i++) begin
      if (in_frac[i]) lz_d = LZW'(NM - 1 - i);
    end
  end

  always_comb begin
    class_d = CLS_NORM;
    if (in_exp == '0) begin
      class_d = (in_frac == '0) ? CLS_ZERO : CLS_SUBN;
    end else if (in_exp == EXP_MAX) begin
      if (in_frac == '0)          class_d = CLS_INF;
      else if (in_frac[NM-1])     class_d = CLS_QNAN;
      else                        class_d = CLS_SNAN;
    end
  end

  assign shamt = EW'(s1_lz_q) + EW'(1);

  always_comb begin
    exp_d  = '0;
    mant_d = '0;
    case (s1_class_q)
      CLS_ZERO: begin
        exp_d  = '0;
        mant_d = '0;
      end
      CLS_SUBN: begin
        mant_d = {1'b0, s1_frac_q} << shamt;
        exp_d  = EW'(1) - BIAS_W - shamt;
      end
      CLS_NORM: begin
        mant_d = {1'b1, s1_frac_q};
        exp_d  = {2'b00, s1_exp_q} - BIAS_W;
      end
      default: begin
        mant_d = {1'b0, s1_frac_q};
        exp_d  = BIAS_W + EW'(1);
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_class_q  <= CLS_ZERO;
      s1_lz_q     <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_class_q <= CLS_ZERO;
    end else if (FLUSH) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= IN_VALID;
        if (IN_VALID) begin
          s1_sign_q  <= IN_DATA[NX+NM];
          s1_exp_q   <= in_exp;
          s1_frac_q  <= in_frac;
          s1_class_q <= class_d;
          s1_lz_q    <= lz_d;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_sign_q  <= s1_sign_q;
          out_exp_q   <= exp_d;
          out_mant_q  <= mant_d;
          out_class_q <= s1_class_q;
        end
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_SIGN  = out_sign_q;
  assign OUT_EXP   = out_exp_q;
  assign OUT_MANT  = out_mant_q;
  assign OUT_CLASS = out_class_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_unpack_stage.sv
// ============================================================================
//  Module   : tb_fp_unpack_stage
//  Purpose  : Self-checking bench for fp_unpack_stage (NX=8, NM=23).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_unpack_stage;

  localparam int NX   = 8;
  localparam int NM   = 23;
  localparam int BIAS = 127;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic [31:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic        OUT_SIGN;
  logic [9:0]  OUT_EXP;
  logic [23:0] OUT_MANT;
  logic [2:0]  OUT_CLASS;
  logic        OUT_VALID;
  logic        OUT_READY;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic   s;
    int     x;
    longint m;
    int     c;
  } exp_t;

  exp_t exp_q[$];

  fp_unpack_stage #(.NX(NX), .NM(NM)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_SIGN  (OUT_SIGN),
    .OUT_EXP   (OUT_EXP),
    .OUT_MANT  (OUT_MANT),
    .OUT_CLASS (OUT_CLASS),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  // Value-level model: the mantissa is doubled until it reaches the hidden-bit weight.
  function automatic exp_t model(input logic [31:0] w);
    exp_t   r;
    int     e;
    longint f;
    e   = int'(w[30:23]);
    f   = longint'(w[22:0]);
    r.s = w[31];
    if (e == 0 && f == 0) begin
      r.x = 0; r.m = 0; r.c = 0;
    end else if (e == 0) begin
      r.m = f;
      r.x = 1 - BIAS;
      while (r.m < (longint'(1) << NM)) begin
        r.m = r.m * 2;
        r.x = r.x - 1;
      end
      r.c = 1;
    end else if (e == 255) begin
      r.m = f;
      r.x = BIAS + 1;
      if (f == 0)                        r.c = 3;
      else if (f >= (longint'(1) << 22)) r.c = 5;
      else                               r.c = 4;
    end else begin
      r.m = f + (longint'(1) << NM);
      r.x = e - BIAS;
      r.c = 2;
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST || FLUSH) begin
      exp_q.delete();
    end else begin
      if (OUT_VALID && OUT_READY && exp_q.size() > 0) void'(exp_q.pop_front());
      if (IN_VALID && IN_READY) exp_q.push_back(model(IN_DATA));
    end
  end

  always @(negedge CLK) begin
    if (!RST && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk("m_sign",  longint'(OUT_SIGN),          longint'(exp_q[0].s));
        chk("m_exp",   longint'($signed(OUT_EXP)),  longint'(exp_q[0].x));
        chk("m_mant",  longint'(OUT_MANT),          exp_q[0].m);
        chk("m_class", longint'(OUT_CLASS),         longint'(exp_q[0].c));
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] w, input logic s, input int x,
                     input longint m, input int c);
    exp_t r;
    r = model(w);
    chk({nm, "_sign"},  longint'(r.s), longint'(s));
    chk({nm, "_exp"},   longint'(r.x), longint'(x));
    chk({nm, "_mant"},  r.m, m);
    chk({nm, "_class"}, longint'(r.c), longint'(c));
  endtask

  task automatic directed(input string nm, input logic [31:0] w, input logic s,
                          input logic [9:0] x, input logic [23:0] m, input logic [2:0] c);
    @(negedge CLK);
    IN_DATA = w; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1 chk({nm, "_in_ready"}, longint'(IN_READY), 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1 chk({nm, "_lat1"}, longint'(OUT_VALID), 0);
    @(negedge CLK);
    #1;
    chk({nm, "_valid"}, longint'(OUT_VALID), 1);
    chk({nm, "_sign"},  longint'(OUT_SIGN),  longint'(s));
    chk({nm, "_exp"},   longint'(OUT_EXP),   longint'(x));
    chk({nm, "_mant"},  longint'(OUT_MANT),  longint'(m));
    chk({nm, "_class"}, longint'(OUT_CLASS), longint'(c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
      FLUSH    = 1'b0;
    end
  endtask

  logic [31:0] bp_w[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h40A00000, 32'h40C00000};
  int          bp_x[6] = '{0, 1, 1, 2, 2, 2};

  initial begin
    int          idx;
    int          nout;
    int          cyc;
    logic        have_prev;
    logic        p_sign;
    logic [9:0]  p_exp;
    logic [23:0] p_mant;
    logic [2:0]  p_class;
    logic [31:0] w;

    RST = 1'b1; FLUSH = 1'b0; IN_DATA = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;

    pin("pin_one",   32'h3F800000, 1'b0, 0,    64'h800000, 2);
    pin("pin_tiny",  32'h00000001, 1'b0, -149, 64'h800000, 1);
    pin("pin_sub",   32'h80400000, 1'b1, -127, 64'h800000, 1);
    pin("pin_ninf",  32'hFF800000, 1'b1, 128,  64'h0,      3);
    pin("pin_qnan",  32'h7FC00001, 1'b0, 128,  64'h400001, 5);
    pin("pin_snan",  32'h7F800001, 1'b0, 128,  64'h000001, 4);

    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_valid", longint'(OUT_VALID), 0);
    chk("rst_sign",  longint'(OUT_SIGN),  0);
    chk("rst_exp",   longint'(OUT_EXP),   0);
    chk("rst_mant",  longint'(OUT_MANT),  0);
    chk("rst_class", longint'(OUT_CLASS), 0);
    chk("rst_ready", longint'(IN_READY),  1);
    @(negedge CLK);
    RST = 1'b0;
    idle(2);

    directed("one",      32'h3F800000, 1'b0, 10'h000, 24'h800000, 3'd2);
    directed("tiny",     32'h00000001, 1'b0, 10'h36B, 24'h800000, 3'd1);
    directed("negsub",   32'h80400000, 1'b1, 10'h381, 24'h800000, 3'd1);
    directed("maxsub",   32'h007FFFFF, 1'b0, 10'h381, 24'hFFFFFE, 3'd1);
    directed("minnorm",  32'h00800000, 1'b0, 10'h382, 24'h800000, 3'd2);
    directed("maxnorm",  32'h7F7FFFFF, 1'b0, 10'h07F, 24'hFFFFFF, 3'd2);
    directed("pi",       32'h40490FDB, 1'b0, 10'h001, 24'hC90FDB, 3'd2);
    directed("neginf",   32'hFF800000, 1'b1, 10'h080, 24'h000000, 3'd3);
    directed("qnan",     32'h7FC00001, 1'b0, 10'h080, 24'h400001, 3'd5);
    directed("snan",     32'h7F800001, 1'b0, 10'h080, 24'h000001, 3'd4);
    directed("negzero",  32'h80000000, 1'b1, 10'h000, 24'h000000, 3'd0);
    idle(2);

    // Backpressure: downstream stalls for the first five cycles.
    idx = 0; nout = 0; cyc = 0; have_prev = 1'b0;
    p_sign = 1'b0; p_exp = '0; p_mant = '0; p_class = '0;
    while (nout < 6 && cyc < 40) begin
      @(negedge CLK);
      OUT_READY = (cyc >= 5);
      IN_VALID  = (idx < 6);
      if (idx < 6) IN_DATA = bp_w[idx];
      #1;
      if (cyc >= 2 && cyc <= 4) chk("bp_in_ready", longint'(IN_READY), 0);
      if (have_prev && OUT_VALID) begin
        chk("bp_hold_sign",  longint'(OUT_SIGN),  longint'(p_sign));
        chk("bp_hold_exp",   longint'(OUT_EXP),   longint'(p_exp));
        chk("bp_hold_mant",  longint'(OUT_MANT),  longint'(p_mant));
        chk("bp_hold_class", longint'(OUT_CLASS), longint'(p_class));
      end
      if (OUT_VALID && OUT_READY) begin
        chk("bp_order_exp", longint'($signed(OUT_EXP)), longint'(bp_x[nout]));
        nout++;
      end
      have_prev = OUT_VALID && !OUT_READY;
      p_sign = OUT_SIGN; p_exp = OUT_EXP; p_mant = OUT_MANT; p_class = OUT_CLASS;
      if (IN_VALID && IN_READY) idx++;
      cyc++;
    end
    chk("bp_count", longint'(nout), 6);
    OUT_READY = 1'b1;
    idle(3);

    // Continuous stream: outputs must occupy cycles 2..17 with no gaps.
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      OUT_READY = 1'b1;
      if (c < 16) begin
        w = (32'(c) * 32'h0A3D70A5) + 32'h00123457;
        if (c == 3)  w = 32'h7FC00000;
        if (c == 7)  w = 32'h00000003;
        if (c == 11) w = 32'hFF800000;
        IN_DATA  = w;
        IN_VALID = 1'b1;
      end else begin
        IN_VALID = 1'b0;
      end
      #1;
      if (c < 16) chk("st_in_ready", longint'(IN_READY), 1);
      chk("st_out_valid", longint'(OUT_VALID), longint'(c >= 2 && c <= 17));
    end
    idle(2);

    // Asynchronous reset with two words in flight.
    OUT_READY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      IN_DATA  = 32'h40000000 + 32'(c);
      IN_VALID = 1'b1;
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1 chk("rstm_pre_valid", longint'(OUT_VALID), 1);
    #1 RST = 1'b1;
    exp_q.delete();
    #1 chk("rstm_valid", longint'(OUT_VALID), 0);
    @(negedge CLK);
    RST = 1'b0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      #1 chk("rstm_quiet", longint'(OUT_VALID), 0);
    end
    directed("post_rst", 32'hC0000000, 1'b1, 10'h001, 24'h800000, 3'd2);
    idle(2);

    // Flush with the pipe full; the same-cycle input must be dropped.
    OUT_READY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      IN_DATA  = 32'h41000000 + 32'(c);
      IN_VALID = 1'b1;
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1 chk("fl_full_ready", longint'(IN_READY), 0);
    @(negedge CLK);
    FLUSH = 1'b1; OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h3F800000;
    #1 chk("fl_in_ready", longint'(IN_READY), 1);
    @(negedge CLK);
    FLUSH = 1'b0; IN_VALID = 1'b0;
    #1 chk("fl_valid", longint'(OUT_VALID), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1 chk("fl_dropped", longint'(OUT_VALID), 0);
    end

    chk("queue_empty", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fp_unpack_stage.md
Name: fp_unpack_stage

Overview:
- Pipelined IEEE754 operand unpacker. Feeds the FPU datapath stages that consume packed `IEEE754(NX, NM)` words.
- Classifies each input word and restores the hidden bit.
- Normalizes subnormals, so the downstream stage always sees a leading-one mantissa and an unbiased signed exponent.
- Valid/ready streaming, 2-stage pipeline, throughput of one word per cycle.

Parameters:
- NX, 8, exponent field width (NX >= 3; NM < 2**NX required).
- NM, 23, mantissa/fraction field width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous pipeline clear.
- IN_DATA  in  1+NX+NM  packed word {sign, exp, mant}, matching `IEEE754(NX, NM)`.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  stage can accept IN_DATA.
- OUT_SIGN  out  1  sign bit.
- OUT_EXP  out  NX+2  signed, unbiased exponent.
- OUT_MANT  out  NM+1  mantissa including hidden/normalized leading bit.
- OUT_CLASS  out  3  0=zero, 1=subnormal, 2=normal, 3=inf, 4=sNaN, 5=qNaN.
- OUT_VALID  out  1  outputs valid.
- OUT_READY  in  1  downstream accepts.

Behaviour:
- BIAS = fp::EXP_OFFSET(NX) = 2**(NX-1)-1. EMAX field = 2**NX-1.
- Reset (async, RST=1): both stage valid flags 0; OUT_VALID=0; OUT_SIGN=0, OUT_EXP=0, OUT_MANT=0, OUT_CLASS=0. IN_READY follows its equation.
- Pipeline:
  - S1 registers the input word, class, and the leading-zero count lz of the fraction (lz = NM when fraction is 0).
  - S2 registers the normalized result.
  - Latency is exactly 2 cycles from the accept edge to OUT_VALID=1, when there is no backpressure.
- Handshake:
  - Transfer in occurs on IN_VALID && IN_READY. Transfer out occurs on OUT_VALID && OUT_READY.
  - s2_adv = !s2_valid || OUT_READY. s1_adv = !s1_valid || s2_adv.
  - IN_READY = s1_adv (combinational, no dependence on IN_VALID).
  - Full throughput with OUT_READY held 1. No bubbles are inserted.
  - While OUT_VALID && !OUT_READY, all OUT_* are held stable.
  - Each accepted word appears exactly once, in order. No drop, no duplicate.
- Classification (e = exp field, f = fraction field):
  - e=0, f=0: zero. OUT_EXP=0, OUT_MANT=0.
  - e=0, f!=0: subnormal. s = lz+1. OUT_MANT = (f << s) truncated to NM+1 bits, so its MSB = 1. OUT_EXP = 1-BIAS-s.
  - 0<e<EMAX: normal. OUT_MANT = {1, f}. OUT_EXP = e-BIAS.
  - e=EMAX, f=0: inf. OUT_MANT = {0, f}. OUT_EXP = BIAS+1.
  - e=EMAX, f!=0: NaN. Class is qNaN if f[NM-1]=1, otherwise sNaN. OUT_MANT = {0, f} (payload preserved). OUT_EXP = BIAS+1.
  - OUT_SIGN is passed through for every class, including zero and NaN.
- Arithmetic: OUT_EXP is computed in NX+2-bit two's complement; no overflow is possible given the parameter constraint. The minimum OUT_EXP is 1-BIAS-NM (-149 for the defaults).
- FLUSH=1 at an edge:
  - Clears both stage valid flags. Data registers are don't-care.
  - An input presented the same cycle is dropped, even though IN_READY may read 1.
  - FLUSH has priority over every transfer.
- Reset mid-operation: in-flight words are discarded immediately (asynchronously). The first accept after RST deasserts behaves as from an empty pipe.
- Pipe full (both stages valid, OUT_READY=0): IN_READY=0.
- Simultaneous pop and push on a full pipe: S2 takes S1, S1 takes the input, and occupancy is unchanged.

Test Plan:
- 0x3F800000 (NX=8, NM=23), OUT_READY=1 -> 2 cycles later: SIGN=0, EXP=0, MANT=0x800000, CLASS=2.
- 0x00000001 -> EXP=-149 (10'h36B), MANT=0x800000, CLASS=1. Also 0x80400000 -> SIGN=1, EXP=-127, MANT=0x800000, CLASS=1.
- 0xFF800000 -> SIGN=1, EXP=128, MANT=0, CLASS=3. 0x7FC00001 -> CLASS=5, MANT=0x400001. 0x7F800001 -> CLASS=4. 0x80000000 -> SIGN=1, CLASS=0.
- Backpressure: stream 6 words 1.0, 2.0, ..., 6.0 with IN_VALID=1 and OUT_READY=0 for 5 cycles, then 1 -> IN_READY=0 after 2 accepts; outputs EXP=0, 1, 1, 2, 2, 2 in order; OUT_* stable while stalled; no loss.
- Continuous stream of 16 words, OUT_READY=1 -> 16 outputs on 16 consecutive cycles starting at cycle 2.
- RST pulse with 2 words in flight -> OUT_VALID=0 immediately, nothing emitted. FLUSH with the pipe full -> OUT_VALID=0 next cycle and the same-cycle input is dropped.
